gpr_file: RTL and testbench

//  Parametrised general-purpose register file for the datapath. Has two independent

---
 rtl/gpr_pkg.sv | 15 +
 rtl/gpr_read_port.sv | 75 +++++++
 rtl/gpr_file.sv | 127 ++++++++++++
 tb/tb_gpr_file.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/gpr_pkg.sv
// gpr_pkg: shared types and defaults for the general-purpose register file.
//   gpr_state_t        : sequencer state (CLEAR walks the array, READY serves requests)
//   DEFAULT_DATA_WIDTH : bits per register
//   DEFAULT_ADDR_WIDTH : address bits, depth is 1 << ADDR_WIDTH
package gpr_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } gpr_state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 3;

endpackage

// File: rtl/gpr_read_port.sv
// gpr_read_port: one synchronous read port of the register file.
// Registers the selected word one cycle after a request, with bypass of a
// same-cycle write to the same address.
// Optional feature macro: GPR_ZERO_REG_EN (address 0 always reads as zero).
// Ports:
//   Clock    in  rising-edge clock
//   nReset   in  synchronous active-low reset
//   Enable   in  file is in READY; requests are ignored otherwise
//   Read     in  read request
//   Addr     in  read address
//   MemData  in  current array word at Addr
//   Write    in  write request on the shared write port
//   AddrW    in  write address
//   DataIn   in  write data
//   DataOut  out registered read data (holds when not reading)
//   Valid    out DataOut was updated at the last edge
module gpr_read_port
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  Enable,
    input  logic                  Read,
    input  logic [ADDR_WIDTH-1:0] Addr,
    input  logic [DATA_WIDTH-1:0] MemData,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] AddrW,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  Valid
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  accept;

    assign accept = Enable && Read;

    always_comb begin
        data_d  = data_q;
        valid_d = 1'b0;
        if (accept) begin
            valid_d = 1'b1;
            // A write landing this cycle must be visible to the reader.
            if (Write && (AddrW == Addr)) begin
                data_d = DataIn;
            end else begin
                data_d = MemData;
            end
`ifdef GPR_ZERO_REG_EN
            // Zero register wins over the bypass path as well.
            if (Addr == '0) begin
                data_d = '0;
            end
`endif
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign DataOut = data_q;
    assign Valid   = valid_q;

endmodule

// File: rtl/gpr_file.sv
// gpr_file: parametrised register file, two synchronous read ports and one
// write port, with a post-reset clear sequencer.
// Optional feature macro: GPR_ZERO_REG_EN (register 0 hardwired to zero).
// Ports:
//   Clock, nReset             clock and synchronous active-low reset
//   ReadA/AddrA/DataOutA/ValidA  read port A
//   ReadB/AddrB/DataOutB/ValidB  read port B
//   Write/AddrW/DataIn        write port
//   Ready                     clear sequence finished, requests accepted
//
// state | meaning
// CLEAR | zero one entry per cycle via clear_ptr, requests ignored
// READY | array initialised, reads and writes served
module gpr_file
    import gpr_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  Clock,
    input  logic                  nReset,
    input  logic                  ReadA,
    input  logic [ADDR_WIDTH-1:0] AddrA,
    output logic [DATA_WIDTH-1:0] DataOutA,
    output logic                  ValidA,
    input  logic                  ReadB,
    input  logic [ADDR_WIDTH-1:0] AddrB,
    output logic [DATA_WIDTH-1:0] DataOutB,
    output logic                  ValidB,
    input  logic                  Write,
    input  logic [ADDR_WIDTH-1:0] AddrW,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic                  Ready
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    gpr_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] clear_ptr_q, clear_ptr_d;
    logic                  ready_q, ready_d;
    logic                  in_ready;
    logic                  write_en;

    assign in_ready = (state_q == READY);

`ifdef GPR_ZERO_REG_EN
    assign write_en = in_ready && Write && (AddrW != '0);
`else
    assign write_en = in_ready && Write;
`endif

    always_comb begin
        state_d     = state_q;
        clear_ptr_d = clear_ptr_q;
        ready_d     = ready_q;
        if (state_q == CLEAR) begin
            clear_ptr_d = clear_ptr_q + 1'b1;
            if (clear_ptr_q == {ADDR_WIDTH{1'b1}}) begin
                state_d = READY;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q     <= CLEAR;
            clear_ptr_q <= '0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            clear_ptr_q <= clear_ptr_d;
            ready_q     <= ready_d;
        end
    end

    // Storage has no reset: contents only change through the clear walk or
    // an accepted write, and are left alone while nReset is low.
    always_ff @(posedge Clock) begin
        if (nReset) begin
            if (state_q == CLEAR) begin
                mem[clear_ptr_q] <= '0;
            end else if (write_en) begin
                mem[AddrW] <= DataIn;
            end
        end
    end

    gpr_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port_a (
        .Clock   (Clock),
        .nReset  (nReset),
        .Enable  (in_ready),
        .Read    (ReadA),
        .Addr    (AddrA),
        .MemData (mem[AddrA]),
        .Write   (Write),
        .AddrW   (AddrW),
        .DataIn  (DataIn),
        .DataOut (DataOutA),
        .Valid   (ValidA)
    );

    gpr_read_port #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_port_b (
        .Clock   (Clock),
        .nReset  (nReset),
        .Enable  (in_ready),
        .Read    (ReadB),
        .Addr    (AddrB),
        .MemData (mem[AddrB]),
        .Write   (Write),
        .AddrW   (AddrW),
        .DataIn  (DataIn),
        .DataOut (DataOutB),
        .Valid   (ValidB)
    );

    assign Ready = ready_q;

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: directed self-checking bench for gpr_file (default parameters).
module tb_gpr_file;

    logic        Clock;
    logic        nReset;
    logic        ReadA, ReadB, Write;
    logic [2:0]  AddrA, AddrB, AddrW;
    logic [15:0] DataIn;
    logic [15:0] DataOutA, DataOutB;
    logic        ValidA, ValidB, Ready;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef GPR_ZERO_REG_EN
    localparam logic [15:0] R0_EXP = 16'h0000;
`else
    localparam logic [15:0] R0_EXP = 16'hFFFF;
`endif

    gpr_file dut (
        .Clock    (Clock),
        .nReset   (nReset),
        .ReadA    (ReadA),
        .AddrA    (AddrA),
        .DataOutA (DataOutA),
        .ValidA   (ValidA),
        .ReadB    (ReadB),
        .AddrB    (AddrB),
        .DataOutB (DataOutB),
        .ValidB   (ValidB),
        .Write    (Write),
        .AddrW    (AddrW),
        .DataIn   (DataIn),
        .Ready    (Ready)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        ReadA = 0; ReadB = 0; Write = 0;
    endtask

    initial begin
        idle();
        AddrA = 0; AddrB = 0; AddrW = 0; DataIn = 0;
        nReset = 0;

        // Reset held 3 cycles
        repeat (3) tick();
        check("rst_ready", {15'b0, Ready}, 16'h0);
        check("rst_valid_a", {15'b0, ValidA}, 16'h0);
        check("rst_data_a", DataOutA, 16'h0);
        check("rst_data_b", DataOutB, 16'h0);

        // Release; Ready low for 8 edges. Write/read in CLEAR are ignored.
        nReset = 1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clr_ready_%0d", i), {15'b0, Ready}, 16'h0);
            if (i == 2) begin
                Write = 1; AddrW = 1; DataIn = 16'hAAAA;
                ReadA = 1; AddrA = 1;
            end else begin
                idle();
            end
            tick();
            check($sformatf("clr_valid_%0d", i), {15'b0, ValidA}, 16'h0);
        end
        idle();
        check("ready_up", {15'b0, Ready}, 16'h1);

        // Read all registers: all zero, R1 not written in CLEAR
        for (int i = 0; i < 8; i++) begin
            ReadA = 1; AddrA = 3'(i);
            ReadB = 1; AddrB = 3'(7 - i);
            tick();
            check($sformatf("clr_rd_a%0d", i), DataOutA, 16'h0);
            check($sformatf("clr_vld_a%0d", i), {15'b0, ValidA}, 16'h1);
            check($sformatf("clr_rd_b%0d", 7 - i), DataOutB, 16'h0);
            check($sformatf("clr_vld_b%0d", i), {15'b0, ValidB}, 16'h1);
        end

        // Write/read
        idle(); Write = 1; AddrW = 3; DataIn = 16'hBEEF;
        tick();
        check("no_read_valid", {15'b0, ValidA}, 16'h0);
        idle(); ReadA = 1; AddrA = 3; ReadB = 1; AddrB = 3;
        tick();
        check("wr_rd_a", DataOutA, 16'hBEEF);
        check("wr_rd_va", {15'b0, ValidA}, 16'h1);
        check("wr_rd_b", DataOutB, 16'hBEEF);

        // Hold when not reading
        idle(); Write = 1; AddrW = 3; DataIn = 16'h0F0F;
        tick();
        check("hold_a", DataOutA, 16'hBEEF);
        check("hold_va", {15'b0, ValidA}, 16'h0);

        // Independent addresses on the two ports
        idle(); Write = 1; AddrW = 6; DataIn = 16'h1234;
        tick();
        Write = 1; AddrW = 7; DataIn = 16'h5678;
        tick();
        idle(); ReadA = 1; AddrA = 6; ReadB = 1; AddrB = 7;
        tick();
        check("indep_a", DataOutA, 16'h1234);
        check("indep_b", DataOutB, 16'h5678);

        // Bypass
        idle(); Write = 1; AddrW = 5; DataIn = 16'h1111;
        tick();
        Write = 1; AddrW = 5; DataIn = 16'h2222;
        ReadA = 1; AddrA = 5; ReadB = 1; AddrB = 3;
        tick();
        check("byp_a", DataOutA, 16'h2222);
        check("byp_b_other", DataOutB, 16'h0F0F);
        // Write to different address must not bypass
        idle(); Write = 1; AddrW = 7; DataIn = 16'h9999;
        ReadA = 1; AddrA = 6;
        tick();
        check("nobyp_a", DataOutA, 16'h1234);
        idle(); ReadB = 1; AddrB = 5; ReadA = 1; AddrA = 7;
        tick();
        check("byp_commit_b", DataOutB, 16'h2222);
        check("wr7_a", DataOutA, 16'h9999);

        // Register 0
        idle(); Write = 1; AddrW = 0; DataIn = 16'hFFFF; ReadA = 1; AddrA = 0;
        tick();
        check("r0_byp_a", DataOutA, R0_EXP);
        idle(); ReadB = 1; AddrB = 0;
        tick();
        check("r0_rd_b", DataOutB, R0_EXP);

        // Reset in READY, then mid-clear reset restarts the walk
        idle(); nReset = 0;
        tick();
        check("rst2_ready", {15'b0, Ready}, 16'h0);
        check("rst2_data_a", DataOutA, 16'h0);
        nReset = 1;
        repeat (4) tick();
        check("mid_ready", {15'b0, Ready}, 16'h0);
        nReset = 0;
        tick();
        nReset = 1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("clr2_ready_%0d", i), {15'b0, Ready}, 16'h0);
            tick();
        end
        check("ready2_up", {15'b0, Ready}, 16'h1);
        ReadA = 1; AddrA = 3; ReadB = 1; AddrB = 5;
        tick();
        check("clr2_r3", DataOutA, 16'h0);
        check("clr2_r5", DataOutB, 16'h0);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
